// File: rtl/wm_pixel_collector.sv
// Collects the watermarked pixel stream, packs pixel pairs into a word FIFO
// and exposes the FIFO, status and pixel count through a small APB window.
module wm_pixel_collector #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Data_Depth      = 8,
  parameter int Fifo_Depth      = 16,
  parameter int Fifo_Addr       = 4,
  parameter int Base_Addr       = 'h1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [Data_Depth-1:0]    Pixel_Data,
  input  logic                     new_pixel,
  input  logic                     Image_Done,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [Amba_Addr_Depth:0] PADDR,
  input  logic [Amba_Word-1:0]     PWDATA,
  output logic [Amba_Word-1:0]     PRDATA,
  output logic                     Frame_Ready
);

  localparam int AW = Amba_Addr_Depth + 1;
  localparam int CW = Fifo_Addr + 1;
  localparam logic [AW-1:0] ADDR_DATA  = AW'(Base_Addr);
  localparam logic [AW-1:0] ADDR_CTRL  = AW'(Base_Addr + 1);
  localparam logic [AW-1:0] ADDR_PIX   = AW'(Base_Addr + 2);
  localparam logic [CW-1:0] COUNT_FULL = CW'(Fifo_Depth);

  logic [Amba_Word-1:0]  mem_r [Fifo_Depth];
  logic [Fifo_Addr-1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_nx_s, wr_ptr_nx_s, wr_idx_s;
  logic [CW-1:0]         count_r, count_nx_s;
  logic [15:0]           pix_count_r;
  logic [Data_Depth-1:0] low_r, low_nx_s;
  logic                  half_valid_r, half_valid_nx_s;
  logic                  overflow_r, odd_r, done_r, flush_req_r, fr_pend_r, fr_pend_nx_s;
  logic                  frame_ready_r;
  logic [Amba_Word-1:0]  prdata_r, rdata_s, push_word_s, fifo_word_s, status_s;
  logic                  push_s, push_ok_s, pop_ok_s, odd_set_s, frame_set_s, ovf_set_s;
  logic                  empty_s, full_s;
  logic                  rd_setup_s, wr_access_s, sel_data_s, sel_ctrl_s, sel_pix_s;
  logic                  clr_s, fifo_clr_s;
  logic                  unused_s;

  assign PRDATA      = prdata_r;
  assign Frame_Ready = frame_ready_r;

  assign rd_setup_s  = PSEL & ~PENABLE & ~PWRITE;
  assign wr_access_s = PSEL & PENABLE & PWRITE;
  assign sel_data_s  = (PADDR == ADDR_DATA);
  assign sel_ctrl_s  = (PADDR == ADDR_CTRL);
  assign sel_pix_s   = (PADDR == ADDR_PIX);
  assign clr_s       = wr_access_s & sel_ctrl_s & PWDATA[0];
  assign fifo_clr_s  = wr_access_s & sel_ctrl_s & PWDATA[1];
  assign unused_s    = ^PWDATA[Amba_Word-1:2];

  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == COUNT_FULL);
  assign status_s    = Amba_Word'({odd_r, frame_ready_r, overflow_r, full_s, empty_s, count_r});
  // With an empty FIFO a same-cycle push is forwarded straight to the reader.
  assign fifo_word_s = empty_s ? push_word_s : mem_r[rd_ptr_r];
  assign pop_ok_s    = rd_setup_s & sel_data_s & (~empty_s | push_s);
  assign push_ok_s   = push_s & (~full_s | pop_ok_s | fifo_clr_s);
  assign ovf_set_s   = push_s & ~push_ok_s;
  assign frame_set_s = (flush_req_r & ~half_valid_r) | fr_pend_r;
  assign wr_idx_s    = fifo_clr_s ? {Fifo_Addr{1'b0}} : wr_ptr_r;

  // Pixel packing and end-of-frame flush of a pending half word
  always_comb begin
    push_s          = 1'b0;
    push_word_s     = {Amba_Word{1'b0}};
    low_nx_s        = low_r;
    half_valid_nx_s = half_valid_r;
    odd_set_s       = 1'b0;
    fr_pend_nx_s    = 1'b0;
    if (flush_req_r && half_valid_r) begin
      push_s       = 1'b1;
      push_word_s  = {{Data_Depth{1'b0}}, low_r};
      odd_set_s    = 1'b1;
      fr_pend_nx_s = 1'b1;
      if (new_pixel) begin
        low_nx_s        = Pixel_Data;
        half_valid_nx_s = 1'b1;
      end else begin
        half_valid_nx_s = 1'b0;
      end
    end else if (new_pixel) begin
      if (half_valid_r) begin
        push_s          = 1'b1;
        push_word_s     = {Pixel_Data, low_r};
        half_valid_nx_s = 1'b0;
      end else begin
        low_nx_s        = Pixel_Data;
        half_valid_nx_s = 1'b1;
      end
    end else begin
      half_valid_nx_s = half_valid_r;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    rd_ptr_nx_s = rd_ptr_r;
    wr_ptr_nx_s = wr_ptr_r;
    count_nx_s  = count_r;
    if (fifo_clr_s) begin
      rd_ptr_nx_s = {Fifo_Addr{1'b0}};
      wr_ptr_nx_s = push_ok_s ? Fifo_Addr'(1) : {Fifo_Addr{1'b0}};
      count_nx_s  = push_ok_s ? CW'(1) : {CW{1'b0}};
    end else begin
      if (pop_ok_s) rd_ptr_nx_s = rd_ptr_r + Fifo_Addr'(1);
      else          rd_ptr_nx_s = rd_ptr_r;
      if (push_ok_s) wr_ptr_nx_s = wr_ptr_r + Fifo_Addr'(1);
      else           wr_ptr_nx_s = wr_ptr_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_nx_s = count_r + CW'(1);
        2'b01:   count_nx_s = count_r - CW'(1);
        default: count_nx_s = count_r;
      endcase
    end
  end

  // APB read mux, sampled in the setup phase and held through access
  always_comb begin
    rdata_s = prdata_r;
    if (rd_setup_s) begin
      if (sel_data_s)     rdata_s = pop_ok_s ? fifo_word_s : {Amba_Word{1'b0}};
      else if (sel_ctrl_s) rdata_s = status_s;
      else if (sel_pix_s)  rdata_s = Amba_Word'(pix_count_r);
      else                 rdata_s = {Amba_Word{1'b0}};
    end else begin
      rdata_s = prdata_r;
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_idx_s] <= push_word_s;
  end

  // Control, flag and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r      <= {Fifo_Addr{1'b0}};
      wr_ptr_r      <= {Fifo_Addr{1'b0}};
      count_r       <= {CW{1'b0}};
      pix_count_r   <= 16'h0000;
      low_r         <= {Data_Depth{1'b0}};
      half_valid_r  <= 1'b0;
      overflow_r    <= 1'b0;
      odd_r         <= 1'b0;
      done_r        <= 1'b0;
      flush_req_r   <= 1'b0;
      fr_pend_r     <= 1'b0;
      frame_ready_r <= 1'b0;
      prdata_r      <= {Amba_Word{1'b0}};
    end else begin
      rd_ptr_r     <= rd_ptr_nx_s;
      wr_ptr_r     <= wr_ptr_nx_s;
      count_r      <= count_nx_s;
      low_r        <= low_nx_s;
      half_valid_r <= clr_s ? 1'b0 : half_valid_nx_s;
      done_r       <= Image_Done;
      flush_req_r  <= Image_Done & ~done_r;
      fr_pend_r    <= fr_pend_nx_s;
      prdata_r     <= rdata_s;
      if (clr_s)                                pix_count_r <= 16'h0000;
      else if (new_pixel && pix_count_r != 16'hFFFF) pix_count_r <= pix_count_r + 16'h0001;
      else                                      pix_count_r <= pix_count_r;
      overflow_r    <= clr_s ? 1'b0 : (overflow_r | ovf_set_s);
      // A frame completion on the same edge as a clear takes precedence.
      odd_r         <= odd_set_s   ? 1'b1 : (clr_s ? 1'b0 : odd_r);
      frame_ready_r <= frame_set_s ? 1'b1 : (clr_s ? 1'b0 : frame_ready_r);
    end
  end

endmodule
